// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the synchronous FIFO and its read-side drain
// controller, so both sides agree on word width, depth and occupancy width.
// No ports (package).
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int FIFO_DEPTH     = 16;

    // Occupancy of the drain's 2-entry output buffer (0..2).
    typedef logic [1:0] occ_t;

    // Occupancy after one cycle of optional push and optional pop.
    function automatic occ_t occ_next(input occ_t occ, input logic push, input logic pop);
        return occ_t'(occ + {1'b0, push} - {1'b0, pop});
    endfunction

endpackage

// File: rtl/fifo_drain_buf2.sv
// -----------------------------------------------------------------------------
// fifo_drain_buf2
// Two-entry ring buffer that absorbs the FIFO's one-cycle read latency.
// Ports:
//   clk, reset        clock, synchronous active-high reset (clears contents)
//   push_i            write push_data_i into the tail slot this cycle
//   push_data_i       word to write
//   pop_i             retire the head word this cycle (ignored when empty)
//   head_o            word at the head (all zeros after reset)
//   occ_o             number of stored words (0..2)
// -----------------------------------------------------------------------------
module fifo_drain_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output occ_t                  occ_o
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [DATA_WIDTH-1:0] mem_d [2];
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    occ_t                  occ_q, occ_d;
    logic                  pop_ok_s;
    logic                  push_ok_s;

    // Next-state for slots, pointers and occupancy.
    always_comb begin
        mem_d     = mem_q;
        head_d    = head_q;
        tail_d    = tail_q;
        pop_ok_s  = pop_i && (occ_q != 2'd0);
        // With both slots full a push is only safe if the head leaves this
        // cycle; the tail then equals the head slot being vacated.
        push_ok_s = push_i && ((occ_q != 2'd2) || pop_ok_s);
        if (push_ok_s) begin
            mem_d[tail_q] = push_data_i;
            tail_d        = ~tail_q;
        end else begin
            tail_d        = tail_q;
        end
        if (pop_ok_s) begin
            head_d = ~head_q;
        end else begin
            head_d = head_q;
        end
        occ_d = occ_next(occ_q, push_ok_s, pop_ok_s);
    end

    // Buffer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= {DATA_WIDTH{1'b0}};
            mem_q[1] <= {DATA_WIDTH{1'b0}};
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            head_q   <= head_d;
            tail_q   <= tail_d;
            occ_q    <= occ_d;
        end
    end

    assign head_o = mem_q[head_q];
    assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_drain.sv
// -----------------------------------------------------------------------------
// fifo_drain
// Read-side controller for the synchronous FIFO: issues read strobes while
// there is credit in a 2-entry output buffer, captures the word returned one
// cycle later and presents it on a valid/ready stream, one word per cycle.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   drain_en     permits new reads (in-flight reads always complete)
//   fifo_empty   FIFO empty flag
//   fifo_data    FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en   FIFO read strobe (combinational)
//   fifo_cs      copy of fifo_rd_en for the FIFO chip-select OR
//   out_valid    downstream word available
//   out_ready    downstream accepts
//   out_data     downstream word
//   busy         buffer non-empty or read in flight
//   xfer_count   accepted-word count, wraps; only counts when the macro
//                FIFO_DRAIN_COUNT_EN is defined, otherwise tied to 0
// -----------------------------------------------------------------------------
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  drain_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  fifo_cs,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  xfer_count
);

    occ_t       occ_s;
    logic       pending_q, pending_d;
    logic       pop_s;
    logic [2:0] credit_s;

    fifo_drain_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .push_i      (pending_q),
        .push_data_i (fifo_data),
        .pop_i       (pop_s),
        .head_o      (out_data),
        .occ_o       (occ_s)
    );

    assign out_valid = (occ_s != 2'd0);
    assign pop_s     = out_valid && out_ready;

    // Slots that will be committed after this cycle; a new strobe is only
    // allowed if its word (arriving next cycle) is guaranteed a slot.
    assign credit_s   = {1'b0, occ_s} + {2'b00, pending_q} - {2'b00, pop_s};
    assign fifo_rd_en = drain_en && !fifo_empty && !reset && (credit_s < 3'd2);
    assign fifo_cs    = fifo_rd_en;
    assign busy       = out_valid || pending_q;

    // A strobe this cycle means data to capture next cycle.
    always_comb begin
        pending_d = fifo_rd_en;
    end

    // In-flight read flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

`ifdef FIFO_DRAIN_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Accepted-word counter, wraps naturally at its width.
    always_comb begin
        if (pop_s) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_count = cnt_q;
`else
    assign xfer_count = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Testbench for fifo_drain: the FIFO is modelled as a queue, the drain as a
// list of words held downstream plus at most one word in flight.
module tb_fifo_drain;

    localparam int DW   = 32;
    localparam int CW   = 4;

    logic          clk;
    logic          reset;
    logic          drain_en;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_en;
    logic          fifo_cs;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic [CW-1:0] xfer_count;

    fifo_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .drain_en   (drain_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .fifo_cs    (fifo_cs),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    logic [DW-1:0] fq[$];      // FIFO contents
    logic [DW-1:0] mq[$];      // words the drain holds for downstream
    logic [DW-1:0] got[$];     // words observed leaving the DUT
    logic [DW-1:0] wr[$];      // words written in the random test
    logic          inflight = 1'b0;
    logic [DW-1:0] inflight_word = '0;
    int            m_cnt = 0;
    int            strobes = 0;
    int            outs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] exp_count();
`ifdef FIFO_DRAIN_COUNT_EN
        return 32'(m_cnt % (1 << CW));
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] lit_count(input int n);
`ifdef FIFO_DRAIN_COUNT_EN
        return 32'(n % (1 << CW));
`else
        return 32'd0 + 32'(n - n);
`endif
    endfunction

    // One clock cycle: compare DUT against the model, then advance both.
    task automatic tick();
        logic exp_valid, pop, exp_rd, dut_pop;
        int   room;
        fifo_empty = (fq.size() == 0);
        #1;
        exp_valid = (mq.size() != 0);
        pop       = exp_valid && out_ready;
        room      = mq.size() + (inflight ? 1 : 0) - (pop ? 1 : 0);
        exp_rd    = !reset && drain_en && (fq.size() != 0) && (room < 2);
        chk("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
        chk("cs", 32'(fifo_cs), 32'(exp_rd));
        chk("valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) chk("data", out_data, mq[0]);
        chk("busy", 32'(busy), 32'(exp_valid || inflight));
        chk("count", 32'(xfer_count), exp_count());
        chk("rd_while_empty", 32'(fifo_rd_en && fifo_empty), 32'd0);
        dut_pop = !reset && out_valid && out_ready;
        if (dut_pop) got.push_back(out_data);
        if (fifo_rd_en) strobes++;
        outs = outs + (fifo_rd_en ? 1 : 0) - (dut_pop ? 1 : 0);
        if (!reset) chk("outstanding_le2", 32'(outs <= 2), 32'd1);
        @(posedge clk);
        #1;
        if (reset) begin
            mq.delete(); fq.delete(); got.delete();
            inflight = 1'b0; m_cnt = 0; strobes = 0; outs = 0;
            fifo_data = '0;
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                m_cnt++;
            end
            if (inflight) mq.push_back(inflight_word);
            inflight = exp_rd;
            if (exp_rd) begin
                inflight_word = fq.pop_front();
                fifo_data     = inflight_word;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int first_valid;
        int budget;
        int nbad;
        logic [DW-1:0] w;

        reset = 1'b1; drain_en = 1'b0; out_ready = 1'b0;
        fifo_data = '0; fifo_empty = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_cs", 32'(fifo_cs), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(xfer_count), 32'd0);

        // Basic order and first-word latency.
        do_reset();
        drain_en = 1'b1; out_ready = 1'b1;
        fq.push_back(32'd1); fq.push_back(32'd10); fq.push_back(32'd100);
        first_valid = -1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid && first_valid < 0) first_valid = i + 1;
        end
        chk("basic_latency", 32'(first_valid), 32'd2);
        chk("basic_n", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("basic_w0", got[0], 32'd1);
            chk("basic_w1", got[1], 32'd10);
            chk("basic_w2", got[2], 32'd100);
        end
        chk("basic_count", 32'(xfer_count), lit_count(3));

        // Stall with 8 words, then release.
        do_reset();
        for (int k = 0; k < 8; k++) fq.push_back(32'd1 << k);
        out_ready = 1'b0;
        repeat (10) tick();
        chk("stall_strobes", 32'(strobes), 32'd2);
        chk("stall_data", out_data, 32'd1);
        chk("stall_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        budget = 0;
        while (got.size() < 8 && budget < 40) begin
            tick();
            budget++;
        end
        chk("stall_n", 32'(got.size()), 32'd8);
        for (int k = 0; k < 8 && k < got.size(); k++) chk("stall_order", got[k], 32'd1 << k);

        // Random back-pressure, 200 words.
        do_reset();
        wr.delete();
        budget = 0;
        while (got.size() < 200 && budget < 4000) begin
            if (wr.size() < 200 && $urandom_range(0, 3) != 0) begin
                for (int j = 0; j < int'($urandom_range(1, 2)) && wr.size() < 200; j++) begin
                    w = $urandom;
                    wr.push_back(w);
                    fq.push_back(w);
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            drain_en  = ($urandom_range(0, 7) != 0);
            tick();
            budget++;
        end
        drain_en = 1'b1;
        chk("rand_n", 32'(got.size()), 32'd200);
        nbad = 0;
        for (int k = 0; k < 200 && k < got.size(); k++) if (got[k] !== wr[k]) nbad++;
        chk("rand_order_errors", 32'(nbad), 32'd0);

        // drain_en dropped one cycle after a strobe.
        do_reset();
        drain_en = 1'b1; out_ready = 1'b1;
        fq.push_back(32'hA5); fq.push_back(32'hB6); fq.push_back(32'hC7);
        tick();
        drain_en = 1'b0;
        repeat (6) tick();
        chk("drop_strobes", 32'(strobes), 32'd1);
        chk("drop_n", 32'(got.size()), 32'd1);
        chk("drop_word", (got.size() > 0) ? got[0] : 32'hFFFF_FFFF, 32'hA5);
        chk("drop_busy", 32'(busy), 32'd0);

        // Reset while a word is held and another is in flight.
        do_reset();
        drain_en = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) fq.push_back(32'h100 + 32'(k));
        repeat (2) tick();
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fifo_empty = 1'b1;
        #1;
        chk("mid_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_data", out_data, 32'd0);
        chk("mid_busy0", 32'(busy), 32'd0);
        chk("mid_count", 32'(xfer_count), 32'd0);
        out_ready = 1'b1;
        repeat (5) tick();
        chk("mid_no_stale", 32'(got.size()), 32'd0);

        // Counter wrap: 17 transfers.
        do_reset();
        drain_en = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 17; k++) fq.push_back(32'h200 + 32'(k));
        repeat (25) tick();
        chk("wrap_n", 32'(got.size()), 32'd17);
        chk("wrap_count", 32'(xfer_count), lit_count(17));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
